// File: rtl/color_fsm_driver_pkg.sv
// Shared types and helpers for the colour-FSM command driver.
// Encodes the target FSM's state space, command codes and its Moore output.
package color_fsm_pkg;

  typedef enum logic [1:0] {
    BLUE     = 2'd0,
    RED      = 2'd1,
    HSV_IDLE = 2'd2
  } color_state_t;

  localparam logic [1:0] CMD_NOP     = 2'h3;
  localparam logic [1:0] OUT_BLUE    = 2'h1;
  localparam logic [1:0] OUT_RED     = 2'h2;
  localparam logic [1:0] TGT_ILLEGAL = 2'h3;

  // Transition function of the controlled FSM, used to keep the shadow copy.
  function automatic color_state_t next_color(color_state_t cur, logic [1:0] c);
    color_state_t nxt;
    nxt = cur;
    case (cur)
      BLUE:     if (c == 2'h1) nxt = RED;
      RED: begin
        case (c)
          2'h0:    nxt = RED;
          2'h1:    nxt = BLUE;
          2'h2:    nxt = HSV_IDLE;
          default: nxt = RED;
        endcase
      end
      HSV_IDLE: if (c == 2'h0) nxt = RED;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] exp_out(color_state_t s);
    return (s == BLUE) ? OUT_BLUE : OUT_RED;
  endfunction

endpackage

// File: rtl/color_fsm_driver_if.sv
// Control-plane request/response handshake of the colour-FSM driver.
interface color_fsm_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_target;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_err;

  modport master (
    output req_valid, req_target, rsp_ready,
    input  req_ready, rsp_valid, rsp_err
  );

  modport slave (
    input  req_valid, req_target, rsp_ready,
    output req_ready, rsp_valid, rsp_err
  );
endinterface

// File: rtl/color_fsm_driver_step_lut.sv
// Combinational single-hop command lookup: which `in` code moves cur_state one
// hop toward target. Blue<->HSV routes through Red; equal/illegal give no-op.
module color_step_lut
  import color_fsm_pkg::*;
(
  input  color_state_t cur_state,
  input  logic [1:0]   target,
  output logic [1:0]   cmd
);

  always_comb begin
    cmd = CMD_NOP;
    case (cur_state)
      BLUE:     if (target == RED || target == HSV_IDLE) cmd = 2'h1;
      RED: begin
        if (target == BLUE)          cmd = 2'h1;
        else if (target == HSV_IDLE) cmd = 2'h2;
      end
      HSV_IDLE: if (target == BLUE || target == RED) cmd = 2'h0;
      default:  cmd = CMD_NOP;
    endcase
  end

endmodule

// File: rtl/color_fsm_driver.sv
// Steers the colour FSM to a requested state one hop at a time, verifying each
// hop against fsm_out after SETTLE_CYCLES; one response per accepted request.
module color_fsm_driver
  import color_fsm_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  color_fsm_driver_if.slave bus,
  output logic [1:0]        cmd,
  input  logic [1:0]        fsm_out,
  output logic [1:0]        cur_state
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  // ST_INIT holds req_ready low for the first cycle out of reset.
  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_ISSUE, ST_SETTLE, ST_CHECK, ST_RESP
  } state_t;

  state_t       state_q, state_d;
  color_state_t cur_q, cur_d;
  logic [1:0]   tgt_q, tgt_d;
  logic [1:0]   cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [1:0]   step_cmd;

  color_step_lut u_step_lut (
    .cur_state (cur_q),
    .target    (tgt_q),
    .cmd       (step_cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cur_q   <= RED;
      tgt_q   <= 2'h0;
      cmd_q   <= CMD_NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cmd_d   = CMD_NOP;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.req_valid) begin
          tgt_d = bus.req_target;
          err_d = 1'b0;
          if (bus.req_target == TGT_ILLEGAL) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (bus.req_target == cur_q) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cmd_d   = step_cmd;
        cur_d   = next_color(cur_q, step_cmd);
        cnt_d   = CW'(SETTLE_CYCLES);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= CW'(1)) state_d = ST_CHECK;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      ST_CHECK: begin
        // A mismatch abandons the move; the shadow keeps its modelled value.
        if (fsm_out != exp_out(cur_q)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tgt_q == cur_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = err_q;
  assign cmd           = cmd_q;
  assign cur_state     = cur_q;

endmodule

// File: tb/tb_color_fsm_driver.sv
// Bench for color_fsm_driver: a behavioural colour FSM plant answers the
// commands; a scoreboard of expected responses is checked by a monitor.
module tb_color_fsm_driver;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] cmd, fsm_out, cur_state;

  always #5 clk = ~clk;

  color_fsm_driver_if bus ();

  color_fsm_driver #(.SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cmd       (cmd),
    .fsm_out   (fsm_out),
    .cur_state (cur_state)
  );

  // Plant transition table [state][in]: 0=Blue 1=Red 2=HSV_idle.
  logic [1:0] nxt_tab [4][4] = '{
    '{2'd0, 2'd1, 2'd0, 2'd0},
    '{2'd1, 2'd0, 2'd2, 2'd1},
    '{2'd1, 2'd2, 2'd2, 2'd2},
    '{2'd3, 2'd3, 2'd3, 2'd3}
  };

  logic [1:0] plant_s;
  logic [1:0] true_out;
  bit         fault_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) plant_s <= 2'd1;
    else        plant_s <= nxt_tab[plant_s][cmd];
  end

  assign true_out = (plant_s == 2'd0) ? 2'h1 : 2'h2;
  assign fsm_out  = fault_on ? ((true_out == 2'h1) ? 2'h2 : 2'h1) : true_out;

  typedef struct {
    int         err;
    int         fin;
    int         lat;
    int         acc;
    int         ncmd;
    int         c [2];
  } exp_t;

  exp_t exp_q [$];
  int   log_val [$];
  int   log_cyc [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_s = 1;
  bit   rand_rdy = 1'b0;
  bit   hold_rdy = 1'b1;
  bit   in_resp = 1'b0;
  int   first_cyc = 0;
  bit   stall_prev = 1'b0;
  int   err_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : hold_rdy;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Command that moves the plant from a to b in one step, found from its table.
  function automatic int hop(input int a, input int b);
    int r;
    r = 3;
    for (int c = 0; c < 3; c++)
      if (r == 3 && int'(nxt_tab[a][c]) == b) r = c;
    return r;
  endfunction

  // Monitor: logs command pulses, checks response hold and scoreboard entries.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (cmd != 2'h3) begin
        log_val.push_back(int'(cmd));
        log_cyc.push_back(cyc);
      end
      if (stall_prev) begin
        check("rsp_valid_hold", int'(bus.rsp_valid), 1);
        check("rsp_err_hold", int'(bus.rsp_err), err_prev);
      end
      if (bus.rsp_valid) begin
        check("req_ready_in_resp", int'(bus.req_ready), 0);
        if (!in_resp) begin
          in_resp   = 1'b1;
          first_cyc = cyc;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("latency", first_cyc - e.acc, e.lat);
          check("rsp_err", int'(bus.rsp_err), e.err);
          check("cur_state", int'(cur_state), e.fin);
          check("cmd_count", log_val.size(), e.ncmd);
          for (int i = 0; i < e.ncmd && i < log_val.size(); i++) begin
            check("cmd_value", log_val[i], e.c[i]);
            check("cmd_cycle", log_cyc[i] - e.acc, 2 + 3 * i);
          end
        end
        log_val.delete();
        log_cyc.delete();
        in_resp  = 1'b0;
        fault_on = 1'b0;
      end
      stall_prev = bus.rsp_valid && !bus.rsp_ready;
      err_prev   = int'(bus.rsp_err);
    end
  end

  task automatic send(input int tgt, input bit bad);
    exp_t e;
    int   hops;
    int   h [2];
    bit   taken;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_target = 2'(tgt);
    taken = 1'b0;
    for (int w = 0; w < 100 && !taken; w++) begin
      @(negedge clk);
      taken = bus.req_ready;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1 (cycle %0d)", cyc);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc  = cyc;
    e.err  = 0;
    e.fin  = model_s;
    e.lat  = 1;
    e.ncmd = 0;
    e.c[0] = 3;
    e.c[1] = 3;
    if (tgt == 3) begin
      e.err = 1;
    end else if (tgt != model_s) begin
      if (model_s != 1 && tgt != 1) begin
        h[0] = hop(model_s, 1);
        h[1] = hop(1, tgt);
        hops = 2;
      end else begin
        h[0] = hop(model_s, tgt);
        h[1] = 3;
        hops = 1;
      end
      e.c[0] = h[0];
      e.c[1] = h[1];
      if (bad) begin
        e.ncmd   = 1;
        e.err    = 1;
        e.lat    = 4;
        e.fin    = (hops == 2) ? 1 : tgt;
        e.c[1]   = 3;
        fault_on = 1'b1;
      end else begin
        e.ncmd = hops;
        e.lat  = 1 + 3 * hops;
        e.fin  = tgt;
      end
    end
    model_s = e.fin;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(negedge clk);
    check(nm, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, int'(bus.req_ready), 0);
    check({nm, "_cmd"}, int'(cmd), 3);
    check({nm, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    check({nm, "_rsp_err"}, int'(bus.rsp_err), 0);
    check({nm, "_cur_state"}, int'(cur_state), 1);
  endtask

  initial begin
    bit seen;
    bus.req_valid  = 1'b0;
    bus.req_target = 2'h0;
    bus.rsp_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed moves: 1-step, 2-step, 1-step back, same state, illegal, faulted.
    send(0, 1'b0);
    send(2, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(3, 1'b0);
    send(0, 1'b1);
    drain("drain_directed");

    // Response stall: hold rsp_ready low for five cycles.
    hold_rdy = 1'b0;
    send(1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    check("stall_rsp_seen", int'(seen), 1);
    repeat (5) @(negedge clk);
    hold_rdy = 1'b1;
    drain("drain_stall");

    // Reset while the first command is settling.
    send(0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (cmd != 2'h3);
    end
    check("settle_cmd_seen", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    log_val.delete();
    log_cyc.delete();
    in_resp    = 1'b0;
    stall_prev = 1'b0;
    fault_on   = 1'b0;
    model_s    = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_abort", int'(bus.rsp_valid), 0);
    end
    send(0, 1'b0);
    drain("drain_post_reset");

    // Randomised targets, faults and response back-pressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++)
      send($urandom_range(0, 3), $urandom_range(0, 7) == 0);
    drain("drain_random");
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
